// File: rtl/sccb_cfg_pkg.sv
// Shared types and constants for the SCCB configuration sequencer.
package sccb_cfg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StIssue,
    StWait,
    StDelay,
    StDone,
    StError
  } state_e;

  // All-ones pattern of width w; END and DELAY entries use it as the address
  // field, and END also uses it as the data field.
  function automatic logic [31:0] marker(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Clock cycles per millisecond, never below one.
  function automatic int unsigned ms_ticks(input int unsigned clk_freq);
    return (clk_freq >= 1000) ? (clk_freq / 1000) : 1;
  endfunction

  // Counter width able to hold 0..n-1, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sccb_cfg_delay.sv
// Millisecond delay down-counter: a tick prescaler feeding a ms counter.
// o_expired is high in the last cycle of the programmed delay.
module sccb_cfg_delay
  import sccb_cfg_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 25_000_000,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_ms,
  input  logic              i_count,
  output logic              o_expired
);

  localparam int unsigned    Ticks      = ms_ticks(CLK_FREQ);
  localparam int unsigned    TickW      = cnt_width(Ticks);
  localparam logic [TickW-1:0] TickReload = TickW'(Ticks - 1);

  logic [TickW-1:0]  r_tick;
  logic [DATA_W-1:0] r_ms;

  assign o_expired = i_count && (r_tick == '0) && (r_ms == DATA_W'(1));

  // Load on DECODE of a delay entry, then count down while the FSM sits in DELAY.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tick <= '0;
      r_ms   <= '0;
    end else if (i_load) begin
      r_tick <= TickReload;
      r_ms   <= i_ms;
    end else if (i_count && (r_ms != '0)) begin
      if (r_tick == '0) begin
        r_tick <= TickReload;
        r_ms   <= r_ms - DATA_W'(1);
      end else begin
        r_tick <= r_tick - TickW'(1);
      end
    end
  end

endmodule

// File: rtl/sccb_config_sequencer.sv
// ROM-driven SCCB register configuration sequencer.
// Optional feature macro: SCCB_CFG_RETRY_EN enables NACK retry and the ERROR path;
// without it every sccb_done counts as success and error/err_index are tied low.
module sccb_config_sequencer
  import sccb_cfg_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 25_000_000,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ROM_AW    = 8,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  output logic [ROM_AW-1:0]        o_rom_addr,
  input  logic [ADDR_W+DATA_W-1:0] i_rom_data,
  input  logic                     i_sccb_ready,
  output logic                     o_sccb_start,
  output logic [ADDR_W-1:0]        o_sccb_addr,
  output logic [DATA_W-1:0]        o_sccb_data,
  input  logic                     i_sccb_done,
  input  logic                     i_sccb_nack,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error,
  output logic [ROM_AW-1:0]        o_err_index
);

  localparam logic [ADDR_W-1:0] MarkAddr = ADDR_W'(marker(ADDR_W));
  localparam logic [DATA_W-1:0] MarkData = DATA_W'(marker(DATA_W));
  localparam logic [ROM_AW-1:0] LastIdx  = ROM_AW'(marker(ROM_AW));
  localparam int unsigned       RetryW   = cnt_width(MAX_RETRY + 1);

  state_e            r_state;
  logic [ROM_AW-1:0] r_rom_addr;
  logic              r_sccb_start;
  logic [ADDR_W-1:0] r_sccb_addr;
  logic [DATA_W-1:0] r_sccb_data;
  logic              r_busy;
  logic              r_done;

  logic [ADDR_W-1:0] w_ent_addr;
  logic [DATA_W-1:0] w_ent_data;
  logic              w_is_end;
  logic              w_is_delay;
  logic              w_delay_load;
  logic              w_expired;
  logic              w_nack;
  logic              w_entry_ok;

  assign {w_ent_addr, w_ent_data} = i_rom_data;
  assign w_is_end     = (w_ent_addr == MarkAddr) && (w_ent_data == MarkData);
  assign w_is_delay   = (w_ent_addr == MarkAddr) && (w_ent_data != MarkData);
  assign w_delay_load = (r_state == StDecode) && w_is_delay && (w_ent_data != '0);

`ifdef SCCB_CFG_RETRY_EN
  localparam logic [RetryW-1:0] MaxRetry = RetryW'(MAX_RETRY);
  logic [RetryW-1:0] r_retry;
  logic              r_error;
  logic [ROM_AW-1:0] r_err_index;
  assign w_nack      = i_sccb_nack;
  assign o_error     = r_error;
  assign o_err_index = r_err_index;
`else
  // Without retry the NACK line and retry limit carry no meaning.
  logic              w_unused_nack;
  logic [RetryW-1:0] w_unused_retry;
  assign w_unused_nack  = i_sccb_nack;
  assign w_unused_retry = RetryW'(MAX_RETRY);
  assign w_nack         = 1'b0;
  assign o_error        = 1'b0;
  assign o_err_index    = '0;
`endif

  // An entry completes on: zero-length delay, clean write completion, or delay expiry.
  assign w_entry_ok = ((r_state == StDecode) && w_is_delay && (w_ent_data == '0)) ||
                      ((r_state == StWait) && i_sccb_done && !w_nack) ||
                      ((r_state == StDelay) && w_expired);

  sccb_cfg_delay #(
    .CLK_FREQ (CLK_FREQ),
    .DATA_W   (DATA_W)
  ) u_delay (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (w_delay_load),
    .i_ms      (w_ent_data),
    .i_count   (r_state == StDelay),
    .o_expired (w_expired)
  );

  assign o_rom_addr   = r_rom_addr;
  assign o_sccb_start = r_sccb_start;
  assign o_sccb_addr  = r_sccb_addr;
  assign o_sccb_data  = r_sccb_data;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

  // Sequencer FSM with registered outputs; entry completion is applied after the case.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_rom_addr   <= '0;
      r_sccb_start <= 1'b0;
      r_sccb_addr  <= '0;
      r_sccb_data  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef SCCB_CFG_RETRY_EN
      r_retry      <= '0;
      r_error      <= 1'b0;
      r_err_index  <= '0;
`endif
    end else begin
      r_sccb_start <= 1'b0;
      r_done       <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_rom_addr <= '0;
            r_busy     <= 1'b1;
            r_state    <= StFetch;
`ifdef SCCB_CFG_RETRY_EN
            r_retry    <= '0;
            r_error    <= 1'b0;
`endif
          end
        end
        StFetch: r_state <= StDecode;
        StDecode: begin
          if (w_is_end) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StDone;
          end else if (w_is_delay) begin
            if (w_delay_load) r_state <= StDelay;
          end else if (i_sccb_ready) begin
            // Master already idle: issue straight away so the request lands
            // in the cycle after DECODE.
            r_sccb_start <= 1'b1;
            r_sccb_addr  <= w_ent_addr;
            r_sccb_data  <= w_ent_data;
            r_state      <= StWait;
          end else begin
            r_state <= StIssue;
          end
        end
        StIssue: begin
          // rom_addr is unchanged, so the ROM still presents this entry.
          if (i_sccb_ready) begin
            r_sccb_start <= 1'b1;
            r_sccb_addr  <= w_ent_addr;
            r_sccb_data  <= w_ent_data;
            r_state      <= StWait;
          end
        end
        StWait: begin
`ifdef SCCB_CFG_RETRY_EN
          if (i_sccb_done && i_sccb_nack) begin
            if (r_retry < MaxRetry) begin
              r_retry <= r_retry + RetryW'(1);
              r_state <= StIssue;
            end else begin
              r_error     <= 1'b1;
              r_err_index <= r_rom_addr;
              r_busy      <= 1'b0;
              r_state     <= StError;
            end
          end
`endif
        end
        StDelay: begin
        end
        StDone:  r_state <= StIdle;
        StError: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase

      if (w_entry_ok) begin
`ifdef SCCB_CFG_RETRY_EN
        r_retry <= '0;
`endif
        if (r_rom_addr == LastIdx) begin
          // Last ROM slot without END: finish rather than wrap to index 0.
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= StDone;
        end else begin
          r_rom_addr <= r_rom_addr + ROM_AW'(1);
          r_state    <= StFetch;
        end
      end
    end
  end

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Self-checking bench for sccb_config_sequencer: ROM model, SCCB master model,
// and a write scoreboard checked on every sccb_start.
module tb_sccb_config_sequencer;

  localparam int unsigned ClkFreq  = 10_000;
  localparam int unsigned Ticks    = ClkFreq / 1000;
  localparam int unsigned MaxRetry = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sccb_ready = 1'b1;
  logic        sccb_done = 1'b0;
  logic        sccb_nack = 1'b0;
  logic [1:0]  rom_addr;
  logic [15:0] rom_data = 16'h0000;
  logic        sccb_start;
  logic [7:0]  sccb_addr;
  logic [7:0]  sccb_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_index;

  logic [15:0] rom [4];

  sccb_config_sequencer #(
    .CLK_FREQ  (ClkFreq),
    .ADDR_W    (8),
    .DATA_W    (8),
    .ROM_AW    (2),
    .MAX_RETRY (MaxRetry)
  ) u_dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_data),
    .i_sccb_ready (sccb_ready),
    .o_sccb_start (sccb_start),
    .o_sccb_addr  (sccb_addr),
    .o_sccb_data  (sccb_data),
    .i_sccb_done  (sccb_done),
    .i_sccb_nack  (sccb_nack),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error),
    .o_err_index  (err_index)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clk) rom_data <= rom[rom_addr];

  // SCCB master: completes each write 10 cycles after the request; NACKs writes to
  // nack_reg until nack_used reaches nack_limit. Not reset by the sequencer.
  int         m_cnt = 0;
  logic [7:0] m_addr = 8'h00;
  int         nack_used = 0;
  int         nack_limit = 0;
  logic [7:0] nack_reg = 8'h00;

  always @(posedge clk) begin
    sccb_done <= 1'b0;
    sccb_nack <= 1'b0;
    if (sccb_start) begin
      m_cnt  <= 10;
      m_addr <= sccb_addr;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else if (m_cnt == 1) begin
      m_cnt     <= 0;
      sccb_done <= 1'b1;
      if (m_addr == nack_reg && nack_used < nack_limit) begin
        sccb_nack <= 1'b1;
        nack_used <= nack_used + 1;
      end
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
    end
  endtask

  // Scoreboard and monitors, sampled on the falling edge.
  logic [15:0] sb[$];
  logic [15:0] sb_want;
  int ncyc = 0;
  int n_starts = 0;
  int n_done = 0;
  int first_start = -1;
  int last_sdone = 0;
  int last_gap = -1;

  always @(negedge clk) begin
    ncyc++;
    if (sccb_done) last_sdone = ncyc;
    if (sccb_start) begin
      n_starts++;
      if (first_start < 0) first_start = ncyc;
      last_gap = ncyc - last_sdone;
      if (sb.size() == 0) begin
        check("unexpected_write", {sccb_addr, sccb_data}, 32'hDEAD);
      end else begin
        sb_want = sb.pop_front();
        check("sccb_write", {sccb_addr, sccb_data}, sb_want);
      end
    end
    if (done) n_done++;
  end

  task automatic launch(output int t0);
    first_start = -1;
    @(negedge clk); #1;
    start = 1'b1;
    t0 = ncyc;
    @(negedge clk); #1;  // still high while busy: must be ignored
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input int base_done, input int budget);
    int i = 0;
    while (n_done == base_done && !error && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    check("end_within_budget", i < budget, 1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_error"}, error, 0);
    check({pfx, "_err_index"}, err_index, 0);
    check({pfx, "_rom_addr"}, rom_addr, 0);
    check({pfx, "_sccb_start"}, sccb_start, 0);
    check({pfx, "_sccb_addr"}, sccb_addr, 0);
    check({pfx, "_sccb_data"}, sccb_data, 0);
  endtask

  initial begin
    int t0;
    int bd;
    int bs;
    int i;

    rom = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk); #1;
    check_reset_outputs("por");

    // Two writes then END.
    rom = '{16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF};
    sb.push_back(16'h1280);
    sb.push_back(16'h1101);
    bd = n_done; bs = n_starts;
    launch(t0);
    check("t1_busy", busy, 1);
    wait_end(bd, 500);
    check("t1_done_count", n_done - bd, 1);
    check("t1_write_count", n_starts - bs, 2);
    check("t1_first_latency", first_start - t0, 3);
    check("t1_done_to_start_gap", last_gap, 3);
    check("t1_busy_after", busy, 0);

    // Zero delay, 2 ms delay, write, END.
    rom = '{16'hFF00, 16'hFF02, 16'h3A04, 16'hFFFF};
    sb.push_back(16'h3A04);
    bd = n_done; bs = n_starts;
    launch(t0);
    wait_end(bd, 500);
    check("t2_first_latency", first_start - t0, 4 + 2 * Ticks + 3);
    check("t2_write_count", n_starts - bs, 1);
    check("t2_done_count", n_done - bd, 1);

    // Two NACKs on 0x40 then success.
    rom = '{16'h4010, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    nack_reg = 8'h40;
    nack_limit = nack_used + 2;
`ifdef SCCB_CFG_RETRY_EN
    repeat (3) sb.push_back(16'h4010);
`else
    sb.push_back(16'h4010);
`endif
    bd = n_done; bs = n_starts;
    launch(t0);
    wait_end(bd, 500);
`ifdef SCCB_CFG_RETRY_EN
    check("t3_write_count", n_starts - bs, 3);
`else
    check("t3_write_count", n_starts - bs, 1);
`endif
    check("t3_done_count", n_done - bd, 1);
    check("t3_error", error, 0);
    nack_limit = nack_used;

    // Persistent NACK on index 1.
    rom = '{16'h1280, 16'h2233, 16'hFFFF, 16'hFFFF};
    nack_reg = 8'h22;
    nack_limit = nack_used + 100;
    sb.push_back(16'h1280);
`ifdef SCCB_CFG_RETRY_EN
    repeat (MaxRetry + 1) sb.push_back(16'h2233);
`else
    sb.push_back(16'h2233);
`endif
    bd = n_done; bs = n_starts;
    launch(t0);
    wait_end(bd, 500);
`ifdef SCCB_CFG_RETRY_EN
    check("t4_error", error, 1);
    check("t4_err_index", err_index, 1);
    check("t4_done_count", n_done - bd, 0);
    check("t4_write_count", n_starts - bs, 1 + MaxRetry + 1);
`else
    check("t4_error", error, 0);
    check("t4_err_index", err_index, 0);
    check("t4_done_count", n_done - bd, 1);
    check("t4_write_count", n_starts - bs, 2);
`endif
    check("t4_busy", busy, 0);
    nack_limit = nack_used;
    sb.push_back(16'h1280);
    sb.push_back(16'h2233);
    bd = n_done;
    launch(t0);
    check("t4_error_cleared", error, 0);
    wait_end(bd, 500);
    check("t4_rerun_done", n_done - bd, 1);
    check("t4_rerun_error", error, 0);

    // Reset in the middle of a 5 ms delay.
    rom = '{16'hFF05, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    bd = n_done;
    launch(t0);
    repeat (10) @(negedge clk);
    #1;
    pulse_reset();
    check_reset_outputs("rst_delay");
    repeat (80) @(negedge clk);
    #1;
    check("rst_delay_no_done", n_done - bd, 0);

    // Reset while waiting for the master, then a fresh run from index 0.
    rom = '{16'h5566, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    sb.push_back(16'h5566);
    bs = n_starts;
    launch(t0);
    i = 0;
    while (n_starts == bs && i < 100) begin
      @(negedge clk); #1;
      i++;
    end
    check("rst_wait_write_seen", i < 100, 1);
    repeat (3) @(negedge clk);
    #1;
    pulse_reset();
    check_reset_outputs("rst_wait");
    repeat (20) @(negedge clk);
    #1;
    check("rst_wait_stray_done_ignored", busy, 0);
    sb.push_back(16'h5566);
    bd = n_done;
    launch(t0);
    wait_end(bd, 500);
    check("rst_rerun_latency", first_start - t0, 3);
    check("rst_rerun_done", n_done - bd, 1);

    // No END: all four entries, then done without wrapping.
    rom = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
    sb.push_back(16'h0102);
    sb.push_back(16'h0304);
    sb.push_back(16'h0506);
    sb.push_back(16'h0708);
    bd = n_done; bs = n_starts;
    launch(t0);
    wait_end(bd, 500);
    check("t6_write_count", n_starts - bs, 4);
    check("t6_done_count", n_done - bd, 1);
    check("t6_rom_addr_no_wrap", rom_addr, 3);
    repeat (15) @(negedge clk);
    #1;
    check("t6_no_extra_write", n_starts - bs, 4);

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
